// File: rtl/lms_ctr_spi_pkg.sv
// Shared constants and types for the lms_ctr SPI slave: register map, status layout, widths.
package lms_ctr_spi_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CPU_W  = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_RX      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_TX      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd3;

    localparam int unsigned ST_ROE  = 1;
    localparam int unsigned ST_FE   = 2;
    localparam int unsigned ST_TOE  = 3;
    localparam int unsigned ST_UR   = 4;
    localparam int unsigned ST_TRDY = 5;
    localparam int unsigned ST_RRDY = 6;
    localparam int unsigned ST_E    = 7;

    // Only the interrupt-capable positions [6:1] are writable in control
    localparam logic [DATA_W-1:0] CTRL_MASK = 8'h7E;

    typedef struct packed {
        logic e;
        logic rrdy;
        logic trdy;
        logic ur;
        logic toe;
        logic fe;
        logic roe;
        logic rsvd;
    } status_t;

endpackage

// File: rtl/lms_ctr_spi_slave_sync.sv
// N-stage synchroniser for an asynchronous pin with registered rise/fall pulses.
// level, rise and fall are aligned: in a rise/fall cycle, level already shows the new value.
module lms_ctr_spi_slave_sync
    #(
        parameter int unsigned STAGES    = 2,
        parameter logic        RESET_VAL = 1'b0
    )
    (
        input  logic clk,
        input  logic reset_n,
        input  logic din,
        output logic level,
        output logic rise,
        output logic fall
    );

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            level  <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            level  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~level;
            fall   <= ~sync_q[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/lms_ctr_spi_slave.sv
// SPI slave (CPOL=0, CPHA=0, LSB first, 8-bit) with an Avalon-MM style register port.
// All SPI pins are oversampled in clk; SCLK must be at most clk/8.
module lms_ctr_spi_slave
    import lms_ctr_spi_pkg::*;
    #(
        parameter int unsigned SYNC_STAGES = 2
    )
    (
        input  logic              clk,
        input  logic              reset_n,
        input  logic              SCLK,
        input  logic              SS_n,
        input  logic              MOSI,
        output logic              MISO,
        output logic              MISO_oe,
        input  logic              spi_select,
        input  logic              read_n,
        input  logic              write_n,
        input  logic [ADDR_W-1:0] mem_addr,
        input  logic [CPU_W-1:0]  data_from_cpu,
        output logic [CPU_W-1:0]  data_to_cpu,
        output logic              irq,
        output logic              dataavailable,
        output logic              readyfordata
    );

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, unused_mosi_rise, unused_mosi_fall;
    logic unused_cpu_hi;

    lms_ctr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .din(SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    lms_ctr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .din(SS_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    lms_ctr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .din(MOSI),
        .level(mosi_level), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign unused_cpu_hi = ^{sclk_level, data_from_cpu[CPU_W-1:DATA_W]};

    logic [DATA_W-1:0] tx_holding_q, tx_holding_d;
    logic [DATA_W-1:0] shift_tx_q,   shift_tx_d;
    logic [DATA_W-1:0] rx_shift_q,   rx_shift_d;
    logic [DATA_W-1:0] rx_holding_q, rx_holding_d;
    logic [DATA_W-1:0] control_q,    control_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [CPU_W-1:0]  rdata_q,      rdata_d;
    logic              trdy_q, trdy_d;
    logic              rrdy_q, rrdy_d;
    logic              roe_q, roe_d, toe_q, toe_d, fe_q, fe_d, ur_q, ur_d;
    logic              skip_fall_q, skip_fall_d;
    logic              miso_q, miso_d, miso_oe_q, miso_oe_d, irq_q, irq_d;

    logic              cpu_rd, cpu_wr, sclk_rise_act, sclk_fall_act, byte_done, reload;
    logic [DATA_W-1:0] rd_mux;
    status_t           status;

    assign cpu_rd        = spi_select & ~read_n;
    assign cpu_wr        = spi_select & ~write_n;
    assign sclk_rise_act = sclk_rise & ~ss_level;
    assign sclk_fall_act = sclk_fall & ~ss_level;
    assign byte_done     = sclk_rise_act && (bit_cnt_q == CNT_W'(DATA_W - 1));
    assign reload        = ss_fall | byte_done;

    assign status = '{e: roe_q | toe_q | fe_q | ur_q, rrdy: rrdy_q, trdy: trdy_q,
                      ur: ur_q, toe: toe_q, fe: fe_q, roe: roe_q, rsvd: 1'b0};

    always_comb begin
        rd_mux = '0;
        case (mem_addr)
            ADDR_RX:      rd_mux = rx_holding_q;
            ADDR_STATUS:  rd_mux = status;
            ADDR_CONTROL: rd_mux = control_q;
            default:      rd_mux = '0;
        endcase
    end

    // Next-state logic; clears are applied before sets so a same-cycle set wins
    always_comb begin
        tx_holding_d = tx_holding_q;
        shift_tx_d   = shift_tx_q;
        rx_shift_d   = rx_shift_q;
        rx_holding_d = rx_holding_q;
        control_d    = control_q;
        bit_cnt_d    = bit_cnt_q;
        rdata_d      = rdata_q;
        trdy_d       = trdy_q;
        rrdy_d       = rrdy_q;
        roe_d        = roe_q;
        toe_d        = toe_q;
        fe_d         = fe_q;
        ur_d         = ur_q;
        skip_fall_d  = skip_fall_q;

        if (cpu_wr && mem_addr == ADDR_STATUS) begin
            roe_d = 1'b0;
            toe_d = 1'b0;
            fe_d  = 1'b0;
            ur_d  = 1'b0;
        end
        if (cpu_wr && mem_addr == ADDR_CONTROL) begin
            control_d = data_from_cpu[DATA_W-1:0] & CTRL_MASK;
        end
        if (cpu_rd) begin
            rdata_d = CPU_W'(rd_mux);
            if (mem_addr == ADDR_RX) begin
                rrdy_d = 1'b0;
            end
        end

        if (sclk_rise_act) begin
            rx_shift_d = {mosi_level, rx_shift_q[DATA_W-1:1]};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (byte_done) begin
                rx_holding_d = rx_shift_d;
                rrdy_d       = 1'b1;
                if (rrdy_q) begin
                    roe_d = 1'b1;
                end
            end
        end

        // The fall right after a byte-boundary reload keeps bit 0 on MISO
        if (sclk_fall_act) begin
            if (skip_fall_q) begin
                skip_fall_d = 1'b0;
            end else begin
                shift_tx_d = {1'b0, shift_tx_q[DATA_W-1:1]};
            end
        end

        if (ss_rise) begin
            skip_fall_d = 1'b0;
            if (bit_cnt_q != '0) begin
                fe_d       = 1'b1;
                bit_cnt_d  = '0;
                rx_shift_d = '0;
            end
        end

        if (reload) begin
            shift_tx_d  = trdy_q ? '0 : tx_holding_q;
            ur_d        = ur_d | trdy_q;
            trdy_d      = 1'b1;
            skip_fall_d = byte_done;
        end

        // A write in the reload cycle is accepted since the holding register is being emptied
        if (cpu_wr && mem_addr == ADDR_TX) begin
            if (trdy_q || reload) begin
                tx_holding_d = data_from_cpu[DATA_W-1:0];
                trdy_d       = 1'b0;
            end else begin
                toe_d = 1'b1;
            end
        end

        miso_d    = shift_tx_d[0];
        miso_oe_d = ~ss_level;
        irq_d     = |(status[ST_RRDY:ST_ROE] & control_q[ST_RRDY:ST_ROE]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_holding_q <= '0;
            shift_tx_q   <= '0;
            rx_shift_q   <= '0;
            rx_holding_q <= '0;
            control_q    <= '0;
            bit_cnt_q    <= '0;
            rdata_q      <= '0;
            trdy_q       <= 1'b1;
            rrdy_q       <= 1'b0;
            roe_q        <= 1'b0;
            toe_q        <= 1'b0;
            fe_q         <= 1'b0;
            ur_q         <= 1'b0;
            skip_fall_q  <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            tx_holding_q <= tx_holding_d;
            shift_tx_q   <= shift_tx_d;
            rx_shift_q   <= rx_shift_d;
            rx_holding_q <= rx_holding_d;
            control_q    <= control_d;
            bit_cnt_q    <= bit_cnt_d;
            rdata_q      <= rdata_d;
            trdy_q       <= trdy_d;
            rrdy_q       <= rrdy_d;
            roe_q        <= roe_d;
            toe_q        <= toe_d;
            fe_q         <= fe_d;
            ur_q         <= ur_d;
            skip_fall_q  <= skip_fall_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            irq_q        <= irq_d;
        end
    end

    assign MISO          = miso_q;
    assign MISO_oe       = miso_oe_q;
    assign data_to_cpu   = rdata_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = trdy_q;

endmodule

// File: doc/lms_ctr_spi_slave.md
# lms_ctr_spi_slave

SPI slave (CPOL=0, CPHA=0, LSB first, 8-bit) with an Avalon-MM-style CPU register port; the far-end counterpart of the lms_ctr SPI master. It lets the FPGA be addressed as an SPI peripheral by an external host. All SPI pins are synchronised into `clk`, so SCLK must be ≤ clk/8. Provides rx/tx holding registers, status/IRQ, and streaming handshake outputs.

## Interface
- SYNC_STAGES, 2, synchroniser depth for SCLK/SS_n/MOSI (≥2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- SCLK, SS_n, MOSI  in  1 each  SPI pins from external master (async to clk)
- MISO  out  1  serial data to master; MISO_oe  out  1  drive enable, =~SS_n (synchronised)
- spi_select, read_n, write_n  in  1 each  CPU access strobes
- mem_addr  in  3  register address; data_from_cpu  in  16; data_to_cpu  out  16
- irq, dataavailable (=RRDY), readyfordata (=TRDY)  out  1 each

## Operation
- Registers: 0 rx data (r, low 8 bits), 1 tx data (w), 2 status (r; any write clears ROE/TOE/FE/UR), 3 control (r/w IRQ enables, same bit positions as status), others read 0.
- Status bits: [7] E=ROE|TOE|FE|UR, [6] RRDY, [5] TRDY, [4] UR (tx underrun), [3] TOE, [2] FE (frame error), [1] ROE, [0] reserved 0.
- Tx path: write to addr 1 with TRDY=1 loads tx_holding, sets primed; with TRDY=0 sets TOE, data dropped. TRDY = ~primed.
- Byte start (SS_n fall, or byte completion while SS_n low): shift_tx ← tx_holding, clear primed; if not primed load 0x00 and set UR. MISO = shift_tx[0].
- SCLK rising: rx_shift ← {MOSI, rx_shift[7:1]}, bit_cnt++. On 8th rise: rx_holding ← shifted byte, set RRDY; if RRDY already 1 set ROE (rx_holding still overwritten); bit_cnt ← 0; reload tx per above.
- SCLK falling: shift_tx ← {0, shift_tx[7:1]} except the fall after a reload (first bit preserved).
- SS_n rising with bit_cnt≠0: set FE, discard partial byte, bit_cnt ← 0. SCLK edges while SS_n high ignored.
- Read of addr 0 clears RRDY. irq = |(status[4:1,6,5] & control enables), registered.
- Simultaneous: byte-complete RRDY set beats addr-0 read clear; status-write clear loses to a same-cycle new error set; CPU tx write in the reload cycle: reload takes the old holding, new write lands in holding with primed=1.

## Timing
- Reset values: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0, dataavailable=0, readyfordata=1, all status 0 except TRDY, control=0, bit_cnt=0.
- Pin → internal action: SYNC_STAGES+1 clk (edge detect registered); MISO update ≤ SYNC_STAGES+2 clk after SCLK fall, within a ≥4-clk half period.
- CPU read: data_to_cpu valid 1 clk after accepted read (spi_select & ~read_n). Write takes effect the cycle after acceptance. One access per cycle, no wait states.
- reset_n asserted mid-byte: everything returns to reset values immediately; first SS_n fall after release starts a clean byte.

## Structure
- Package lms_ctr_spi_pkg: register address constants, status/control bit indices, DATA_W=8.
- Sub-module lms_ctr_spi_slave_sync: N-stage synchroniser + rise/fall detect, instanced for SCLK and SS_n; MOSI uses the same sync without edge detect.

## Test plan
- Write 0xA5, master clocks 1 byte sending 0x3C at clk/8 → MISO LSB-first 1,0,1,0,0,1,0,1; rx reads 0x3C; RRDY 1→0 after read.
- Two bytes back-to-back without reading → ROE=1, rx = second byte, irq=1 when ROE enable set.
- Master clocks with no tx written → MISO all 0, UR=1; status write clears UR/E.
- Two tx writes without transfer → second sets TOE, holding keeps first value.
- SS_n raised after 3 bits → FE=1, no RRDY; next full byte received correctly.
- reset_n pulsed mid-byte → outputs at reset values, following 0x81 transfer correct.
